uart_tx_framed: RTL and testbench

//   Parametrised UART transmitter. Runs on the system clock with an internal baud

---
 rtl/uart_tx_framed.sv | 135 +++++++++++++
 tb/tb_uart_tx_framed.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
`timescale 1ns/1ps
// UART transmitter fed by a valid/ready byte source. An internal baud divider
// times each bit; frames are start, LSB-first data, optional parity, 1-2 stops.
module uart_tx_framed #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [2:0]           dbg_state_o
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_tx_framed: illegal parameter combination");
    end

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 baud_last;

    // Handshake: a character is taken on any rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, and tx_valid is ignored in every other state.
    assign tx_ready    = (state_q == S_IDLE);
    assign tx_busy     = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
    assign baud_last   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_done  = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    // Shifting keeps the current bit at shift_q[0].
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        tx_done = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_START:  tx_serial = 1'b0;
            S_DATA:   tx_serial = shift_q[0];
            S_PARITY: tx_serial = parity_q;
            default:  tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_framed: four fast instances (CLKS_PER_BIT=4) in
// different framings plus one at 868 clocks per bit on a 100 MHz clock.
module tb_uart_tx_framed;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // index 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2, 4: 8N1 @ 868
  logic       valid[5];
  logic [7:0] data[5];
  logic [6:0] data7;
  logic       ready[5], serial[5], busy[5], done[5];
  logic [2:0] dbg[5];

  int total = 0;
  int bad = 0;

  logic line_s[128];
  logic done_s[128];
  logic ready_s[128];
  logic [0:0] exp_q[$];

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
    .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0]), .dbg_state_o(dbg[0]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
    .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1]), .dbg_state_o(dbg[1]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
    .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2]), .dbg_state_o(dbg[2]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data7), .tx_valid(valid[3]), .tx_ready(ready[3]),
    .tx_serial(serial[3]), .tx_busy(busy[3]), .tx_done(done[3]), .dbg_state_o(dbg[3]));
  uart_tx_framed #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_868 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[4]), .tx_valid(valid[4]), .tx_ready(ready[4]),
    .tx_serial(serial[4]), .tx_busy(busy[4]), .tx_done(done[4]), .dbg_state_o(dbg[4]));

  // Presents one character for a single accepting edge; returns at the first START sample.
  task automatic start_frame(input int k, input logic [7:0] d);
    @(posedge clk); #1;
    if (k == 3) data7 = d[6:0];
    else data[k] = d;
    valid[k] = 1'b1;
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  task automatic capture(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      line_s[c]  = serial[k];
      done_s[c]  = done[k];
      ready_s[c] = ready[k];
      @(posedge clk); #1;
    end
  endtask

  // Bit j of v is the line level during bit period j of the frame.
  task automatic load_exp(input logic [15:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) exp_q.push_back(v[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid[k] = 1'b0;
      data[k]  = 8'h00;
    end
    data7 = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (ready[k] !== 1'b1 || serial[k] !== 1'b1 || busy[k] !== 1'b0 ||
          done[k] !== 1'b0 || dbg[k] !== 3'd0) begin
        bad++;
        $display("FAIL reset_state dut=%0d got rdy=%b ser=%b busy=%b done=%b st=%0d exp 1 1 0 0 0",
                 k, ready[k], serial[k], busy[k], done[k], dbg[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b1 || serial[0] !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset got rdy=%b ser=%b exp 1 1", ready[0], serial[0]);
    end
  endtask

  task automatic test_8n1;
    exp_q.delete();
    load_exp({6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    start_frame(0, 8'hA5);
    total++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL 8n1_accept got rdy=%b busy=%b exp 0 1", ready[0], busy[0]);
    end
    capture(0, 40);
    for (int c = 0; c < 40; c++) begin
      total++;
      if (line_s[c] !== exp_q[c/4]) begin
        bad++;
        $display("FAIL 8n1_line c=%0d got=%b exp=%b", c, line_s[c], exp_q[c/4]);
      end
      total++;
      if (done_s[c] !== (c == 39)) begin
        bad++;
        $display("FAIL 8n1_done c=%0d got=%b exp=%b", c, done_s[c], (c == 39));
      end
    end
    total++;
    if (ready[0] !== 1'b1 || serial[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      bad++;
      $display("FAIL 8n1_end got rdy=%b ser=%b busy=%b done=%b exp 1 1 0 0",
               ready[0], serial[0], busy[0], done[0]);
    end
  endtask

  task automatic test_parity;
    for (int k = 1; k <= 2; k++) begin
      exp_q.delete();
      // 8'h07 has three ones: even parity bit 1, odd parity bit 0
      if (k == 1) load_exp({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      else load_exp({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      start_frame(k, 8'h07);
      capture(k, 44);
      for (int c = 0; c < 44; c++) begin
        total++;
        if (line_s[c] !== exp_q[c/4]) begin
          bad++;
          $display("FAIL parity_line dut=%0d c=%0d got=%b exp=%b", k, c, line_s[c], exp_q[c/4]);
        end
        total++;
        if (done_s[c] !== (c == 43)) begin
          bad++;
          $display("FAIL parity_done dut=%0d c=%0d got=%b exp=%b", k, c, done_s[c], (c == 43));
        end
      end
      total++;
      if (ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        bad++;
        $display("FAIL parity_end dut=%0d got rdy=%b busy=%b exp 1 0", k, ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_7n2;
    exp_q.delete();
    load_exp({6'd0, 2'b11, 7'h41, 1'b0}, 10);
    start_frame(3, 8'h41);
    capture(3, 40);
    for (int c = 0; c < 40; c++) begin
      total++;
      if (line_s[c] !== exp_q[c/4]) begin
        bad++;
        $display("FAIL 7n2_line c=%0d got=%b exp=%b", c, line_s[c], exp_q[c/4]);
      end
      total++;
      if (done_s[c] !== (c == 39)) begin
        bad++;
        $display("FAIL 7n2_done c=%0d got=%b exp=%b", c, done_s[c], (c == 39));
      end
    end
    total++;
    if (ready[3] !== 1'b1 || busy[3] !== 1'b0) begin
      bad++;
      $display("FAIL 7n2_end got rdy=%b busy=%b exp 1 0", ready[3], busy[3]);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_bit;
    exp_q.delete();
    load_exp({6'd0, 1'b1, 8'h55, 1'b0}, 10);
    load_exp({6'd0, 1'b1, 8'hAA, 1'b0}, 10);
    @(posedge clk); #1;
    data[0]  = 8'h55;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    data[0] = 8'hAA;
    capture(0, 81);
    valid[0] = 1'b0;
    for (int c = 0; c < 81; c++) begin
      if (c < 40) exp_bit = exp_q[c/4];
      else if (c == 40) exp_bit = 1'b1;
      else exp_bit = exp_q[10 + (c - 41)/4];
      total++;
      if (line_s[c] !== exp_bit) begin
        bad++;
        $display("FAIL b2b_line c=%0d got=%b exp=%b", c, line_s[c], exp_bit);
      end
      total++;
      if (ready_s[c] !== (c == 40)) begin
        bad++;
        $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ready_s[c], (c == 40));
      end
      total++;
      if (done_s[c] !== (c == 39 || c == 80)) begin
        bad++;
        $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_s[c], (c == 39 || c == 80));
      end
    end
    @(posedge clk); #1;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_third got busy=%b exp 0", busy[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    start_frame(0, 8'hA5);
    repeat (9) @(posedge clk);
    #1;
    // bit 1 of 8'hA5 is 0, so the line is low right before reset
    total++;
    if (serial[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_line got=%b exp=0", serial[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (serial[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_immediate got ser=%b rdy=%b busy=%b done=%b exp 1 1 0 0",
               serial[0], ready[0], busy[0], done[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (done[0] !== 1'b0 || serial[0] !== 1'b1) begin
        bad++;
        $display("FAIL rst_hold i=%0d got done=%b ser=%b exp 0 1", i, done[0], serial[0]);
      end
    end
    rst_n = 1'b1;
    exp_q.delete();
    load_exp({6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    start_frame(0, 8'h3C);
    capture(0, 40);
    for (int c = 0; c < 40; c++) begin
      total++;
      if (line_s[c] !== exp_q[c/4]) begin
        bad++;
        $display("FAIL rst_after_line c=%0d got=%b exp=%b", c, line_s[c], exp_q[c/4]);
      end
      total++;
      if (done_s[c] !== (c == 39)) begin
        bad++;
        $display("FAIL rst_after_done c=%0d got=%b exp=%b", c, done_s[c], (c == 39));
      end
    end
  endtask

  task automatic test_baud_868;
    time t_last;
    time dt;
    logic prev;
    int ntrans;
    bit finished;
    start_frame(4, 8'h55);
    total++;
    if (serial[4] !== 1'b0) begin
      bad++;
      $display("FAIL baud_start got=%b exp=0", serial[4]);
    end
    t_last   = $time;
    prev     = 1'b0;
    ntrans   = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 10 * 868 + 200; cyc++) begin
      @(posedge clk); #1;
      if (serial[4] !== prev) begin
        dt = $time - t_last;
        total++;
        if (dt != 8680) begin
          bad++;
          $display("FAIL baud_width edge=%0d got=%0t ns exp=8680 ns", ntrans, dt);
        end
        t_last = $time;
        prev   = serial[4];
        ntrans++;
      end
      if (done[4] === 1'b1) begin
        // done marks the last clock of the stop bit, so add one period
        dt = $time - t_last + 10;
        total++;
        if (dt != 8680) begin
          bad++;
          $display("FAIL baud_stop_width got=%0t ns exp=8680 ns", dt);
        end
        finished = 1'b1;
        break;
      end
    end
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL baud_timeout got no tx_done exp tx_done within budget");
    end
    total++;
    if (ntrans != 9) begin
      bad++;
      $display("FAIL baud_transitions got=%0d exp=9", ntrans);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_868();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
